// File: rtl/register_status_table.sv
// Register status table: per architectural register, a pending flag and producer tag.
// Latency: reads and regfile write enables are combinational; updates land at the next clk edge.
// Backpressure: none. Dispatch and CDB are accepted every cycle, and dispatch wins a same-entry collision.
module register_status_table #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int TAG_W    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TAG_W-1:0]    dispatch_tag,
    input  logic                dispatch_valid,
    input  logic [ADDR_W-1:0]   dispatch_addr,
    input  logic                dispatch_wen,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic                cdb_valid,
    output logic [NUM_REGS-1:0] regfile_wen_onehot,
    input  logic [ADDR_W-1:0]   dispatch_rsaddr,
    output logic [TAG_W-1:0]    dispatch_rstag,
    output logic                dispatch_rsvalid,
    input  logic [ADDR_W-1:0]   dispatch_rtaddr,
    output logic [TAG_W-1:0]    dispatch_rttag,
    output logic                dispatch_rtvalid
);

    // Per-entry view of the table; entry 0 is a hard-wired "never pending".
    logic [TAG_W-1:0]    w_tag   [NUM_REGS];
    logic [NUM_REGS-1:0] w_valid;
    logic [NUM_REGS-1:0] w_cdb_match;
    logic                w_disp_we;

    // A rename only happens for a real instruction that writes a non-zero register.
    assign w_disp_we = dispatch_valid && dispatch_wen && (dispatch_addr != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign w_tag[gi]       = '0;
                assign w_valid[gi]     = 1'b0;
                assign w_cdb_match[gi] = 1'b0;
            end else begin : g_reg
                logic [TAG_W-1:0] r_tag;
                logic             r_valid;
                logic             w_sel;

                assign w_sel           = w_disp_we && (dispatch_addr == ADDR_W'(gi));
                assign w_cdb_match[gi] = cdb_valid && r_valid && (r_tag == cdb_tag);
                assign w_tag[gi]       = r_tag;
                assign w_valid[gi]     = r_valid;

                // Entry update: reset first, then a rename (which overrides a same-cycle CDB clear),
                // then the CDB clear. The tag is kept when the entry clears.
                always_ff @(posedge clk) begin
                    if (!reset) begin
                        r_tag   <= '0;
                        r_valid <= 1'b0;
                    end else if (w_sel) begin
                        r_tag   <= dispatch_tag;
                        r_valid <= 1'b1;
                    end else if (w_cdb_match[gi]) begin
                        r_valid <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // A register file write is due for every entry whose producer broadcasts this cycle,
    // even when dispatch is renaming that entry in the same cycle.
    assign regfile_wen_onehot = w_cdb_match;

    // Operand reads with a CDB bypass: a value that completes this cycle reads as available.
    assign dispatch_rstag   = w_tag[dispatch_rsaddr];
    assign dispatch_rsvalid = w_valid[dispatch_rsaddr]
                              && !(cdb_valid && (w_tag[dispatch_rsaddr] == cdb_tag));
    assign dispatch_rttag   = w_tag[dispatch_rtaddr];
    assign dispatch_rtvalid = w_valid[dispatch_rtaddr]
                              && !(cdb_valid && (w_tag[dispatch_rtaddr] == cdb_tag));

endmodule

// File: tb/tb_register_status_table.sv
// Bench for register_status_table: a behavioural table model feeds an expected-result queue.
// Latency: outputs are checked 1 ns after the inputs settle, and the model steps at each posedge.
// Backpressure: not applicable.
module tb_register_status_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  dispatch_tag;
    logic        dispatch_valid;
    logic [4:0]  dispatch_addr;
    logic        dispatch_wen;
    logic [5:0]  cdb_tag;
    logic        cdb_valid;
    logic [31:0] regfile_wen_onehot;
    logic [4:0]  dispatch_rsaddr;
    logic [5:0]  dispatch_rstag;
    logic        dispatch_rsvalid;
    logic [4:0]  dispatch_rtaddr;
    logic [5:0]  dispatch_rttag;
    logic        dispatch_rtvalid;

    register_status_table dut (
        .clk                (clk),
        .reset              (rst_n),
        .dispatch_tag       (dispatch_tag),
        .dispatch_valid     (dispatch_valid),
        .dispatch_addr      (dispatch_addr),
        .dispatch_wen       (dispatch_wen),
        .cdb_tag            (cdb_tag),
        .cdb_valid          (cdb_valid),
        .regfile_wen_onehot (regfile_wen_onehot),
        .dispatch_rsaddr    (dispatch_rsaddr),
        .dispatch_rstag     (dispatch_rstag),
        .dispatch_rsvalid   (dispatch_rsvalid),
        .dispatch_rtaddr    (dispatch_rtaddr),
        .dispatch_rttag     (dispatch_rttag),
        .dispatch_rtvalid   (dispatch_rtvalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] oh;
        logic [5:0]  rs_tag;
        logic        rs_vld;
        logic [5:0]  rt_tag;
        logic        rt_vld;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [5:0]  m_tag   [32];
    logic        m_valid [32];
    logic [31:0] obs_oh;
    logic [5:0]  obs_rs_tag, obs_rt_tag;
    logic        obs_rs_vld, obs_rt_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_tag[i]   = '0;
            m_valid[i] = 1'b0;
        end
    endtask

    // One cycle: drive the inputs, push the model prediction, compare the outputs, then step the model at the edge.
    task automatic cyc(input logic dv, input logic dw, input logic [4:0] da, input logic [5:0] dt,
                       input logic cv, input logic [5:0] ct, input logic [4:0] rs, input logic [4:0] rt);
        exp_t e, g;
        dispatch_valid = dv; dispatch_wen = dw; dispatch_addr = da; dispatch_tag = dt;
        cdb_valid = cv; cdb_tag = ct; dispatch_rsaddr = rs; dispatch_rtaddr = rt;
        #1;
        e.oh = '0;
        for (int i = 1; i < 32; i++)
            e.oh[i] = cv && m_valid[i] && (m_tag[i] == ct);
        e.rs_tag = m_tag[rs];
        e.rs_vld = m_valid[rs] && !(cv && m_tag[rs] == ct);
        e.rt_tag = m_tag[rt];
        e.rt_vld = m_valid[rt] && !(cv && m_tag[rt] == ct);
        exp_q.push_back(e);

        obs_oh = regfile_wen_onehot;
        obs_rs_tag = dispatch_rstag; obs_rs_vld = dispatch_rsvalid;
        obs_rt_tag = dispatch_rttag; obs_rt_vld = dispatch_rtvalid;
        g = exp_q.pop_front();
        chk("onehot", obs_oh, g.oh);
        chk("rstag", 32'(obs_rs_tag), 32'(g.rs_tag));
        chk("rsvalid", 32'(obs_rs_vld), 32'(g.rs_vld));
        chk("rttag", 32'(obs_rt_tag), 32'(g.rt_tag));
        chk("rtvalid", 32'(obs_rt_vld), 32'(g.rt_vld));

        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int i = 1; i < 32; i++)
                if (cv && m_valid[i] && m_tag[i] == ct) m_valid[i] = 1'b0;
            if (dv && dw && da != 5'd0) begin
                m_tag[da]   = dt;
                m_valid[da] = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        dispatch_valid = 0; dispatch_wen = 0; dispatch_addr = 0; dispatch_tag = 0;
        cdb_valid = 0; cdb_tag = 0; dispatch_rsaddr = 0; dispatch_rtaddr = 0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;

        // Case 1: valid instructions that do not write a register never mark an entry pending.
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 5'(i), 6'(i), 0, 0, 5'(i), 5'(i));
            chk("c1_rsvalid", 32'(obs_rs_vld), 0);
            chk("c1_onehot", obs_oh, 0);
        end

        // Case 2: rename every register, then read all of them back.
        for (int i = 0; i < 32; i++)
            cyc(1, 1, 5'(i), 6'(i), 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 5'(i), 5'(i));
            chk("c2_rstag", 32'(obs_rs_tag), (i == 0) ? 0 : i);
            chk("c2_rsvalid", 32'(obs_rs_vld), (i == 0) ? 0 : 1);
            chk("c2_rtvalid", 32'(obs_rt_vld), (i == 0) ? 0 : 1);
        end

        // Case 3: broadcast every tag, then confirm that every entry has cleared.
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 0, 1, 6'(i), 0, 0);
            chk("c3_onehot", obs_oh, (i == 0) ? 32'd0 : (32'd1 << i));
        end
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 5'(i), 5'(i));
            chk("c3_cleared", 32'(obs_rs_vld | obs_rt_vld), 0);
        end

        // Case 4: a CDB broadcast bypasses to a read in the same cycle.
        cyc(1, 1, 5, 9, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 9, 5, 5);
        chk("c4_rsvalid", 32'(obs_rs_vld), 0);
        chk("c4_rstag", 32'(obs_rs_tag), 9);

        // Case 5: a rename and a CDB clear hit the same entry, and the rename wins.
        cyc(1, 1, 7, 3, 0, 0, 0, 0);
        cyc(1, 1, 7, 12, 1, 3, 0, 0);
        chk("c5_onehot", obs_oh, 32'h80);
        cyc(0, 0, 0, 0, 0, 0, 7, 7);
        chk("c5_valid", 32'(obs_rs_vld), 1);
        chk("c5_tag", 32'(obs_rs_tag), 12);

        // Case 6: one broadcast clears several entries, then a reset arrives mid-operation.
        cyc(1, 1, 2, 6, 0, 0, 0, 0);
        cyc(1, 1, 4, 6, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 6, 2, 4);
        chk("c6_onehot", obs_oh, 32'h14);
        cyc(0, 0, 0, 0, 0, 0, 2, 4);
        chk("c6_cleared", 32'(obs_rs_vld | obs_rt_vld), 0);
        cyc(1, 1, 10, 33, 0, 0, 0, 0);
        cyc(1, 1, 11, 34, 0, 0, 0, 0);
        rst_n = 1'b0;
        cyc(1, 1, 12, 35, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 10, 11);
        chk("c6_rst_valid", 32'(obs_rs_vld | obs_rt_vld), 0);
        chk("c6_rst_tag", 32'(obs_rs_tag), 0);
        cyc(0, 0, 0, 0, 1, 0, 12, 0);
        chk("c6_rst_onehot", obs_oh, 0);

        // Random traffic with a small tag space, so that tags collide and reuse often.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            cyc(1'($urandom), 1'($urandom), 5'($urandom), 6'($urandom_range(0, 7)),
                1'($urandom), 6'($urandom_range(0, 7)), 5'($urandom), 5'($urandom));
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
